// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM encoding and width default for the HI/LO unit
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // Signed variants need magnitude conversion and a sign fix at the end.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - one restoring shift-subtract divide step
// Ports:
//   rem      partial remainder in
//   quo      dividend bits still to shift in (MSB first), quotient bits accumulate at LSB
//   divisor  divisor magnitude
//   rem_next partial remainder after this step
//   quo_next shifted quotient/dividend register after this step
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    // A borrow out of the top bit means the trial subtract went negative: restore.
    if (diff[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - multi-cycle multiply/divide unit owning the HI/LO registers
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start, op     request strobe and operation code (muldiv_pkg constants)
//   busA, busB    rs / rt operands
//   flush         cancel an in-flight operation
//   busy          operation in flight, HI/LO not yet valid
//   done          one-cycle pulse after HI/LO are committed
//   Hout, Lout    HI and LO register contents
// Build option: MULDIV_FAST_MULT_EN makes MULT/MULTU single-cycle using native multiply.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hout,
  output logic [WIDTH-1:0] Lout
);

  localparam int CW = $clog2(ITERS + 1);

  md_state_t          state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // product, or {remainder, quotient}
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               is_div;
  logic               neg_q;    // result/quotient must be negated
  logic               neg_r;    // remainder takes dividend sign
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic               is_mul_op;
  logic               is_div_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  always_comb begin
    is_mul_op = (op == MD_MULT) || (op == MD_MULTU);
    is_div_op = (op == MD_DIV) || (op == MD_DIVU);
    a_neg     = md_is_signed(op) & busA[WIDTH-1];
    b_neg     = md_is_signed(op) & busB[WIDTH-1];
    a_abs     = a_neg ? -busA : busA;
    b_abs     = b_neg ? -busB : busB;
`ifdef MULDIV_FAST_MULT_EN
    accept    = (state == ST_IDLE) && start && !flush && is_div_op;
`else
    accept    = (state == ST_IDLE) && start && !flush && (is_mul_op || is_div_op);
`endif
    // Shift-add: add multiplicand into the upper half when the multiplier LSB is set.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
  end

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  always_comb begin
    if (op == MD_MULT)
      fast_prod = $signed({{WIDTH{busA[WIDTH-1]}}, busA}) * $signed({{WIDTH{busB[WIDTH-1]}}, busB});
    else
      fast_prod = {{WIDTH{1'b0}}, busA} * {{WIDTH{1'b0}}, busB};
  end
`endif

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .quo      (acc[WIDTH-1:0]),
    .divisor  (b_mag),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_RUN;
            cnt    <= '0;
            busy   <= 1'b1;
            a_mag  <= a_abs;
            b_mag  <= b_abs;
            is_div <= is_div_op;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
            acc    <= {{WIDTH{1'b0}}, is_div_op ? a_abs : b_abs};
          end else if (start && !flush) begin
            if (op == MD_MTHI) begin
              hi   <= busA;
              done <= 1'b1;
            end else if (op == MD_MTLO) begin
              lo   <= busA;
              done <= 1'b1;
            end
`ifdef MULDIV_FAST_MULT_EN
            else if (is_mul_op) begin
              hi   <= fast_prod[2*WIDTH-1:WIDTH];
              lo   <= fast_prod[WIDTH-1:0];
              done <= 1'b1;
            end
`endif
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div)
              acc <= {rem_next, quo_next};
            else
              acc <= {mul_sum, acc[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
            if (cnt == CW'(ITERS - 1))
              state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              if (b_mag == '0) begin
                // Divide by zero hands back the original dividend and an all-ones quotient.
                hi <= neg_r ? -a_mag : a_mag;
                lo <= '1;
              end else begin
                hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
              end
            end else begin
              hi <= neg_q ? -acc[2*WIDTH-1:WIDTH] - {{(WIDTH-1){1'b0}}, (acc[WIDTH-1:0] == '0) ? 1'b0 : 1'b1} + {{(WIDTH-1){1'b0}}, (acc[WIDTH-1:0] == '0) ? 1'b0 : 1'b1} - {{(WIDTH-1){1'b0}}, (acc[WIDTH-1:0] != '0)} : acc[2*WIDTH-1:WIDTH];
              lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Hout = hi;
  assign Lout = lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - directed self-checking bench for muldiv_hilo
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hout;
  logic [31:0] lout;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_BUSY = 0;
  localparam logic [2:0] FLUSH_OP = MD_DIVU;
`else
  localparam int MUL_BUSY = 33;
  localparam logic [2:0] FLUSH_OP = MD_MULTU;
`endif

  muldiv_hilo dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .busA  (bus_a),
    .busB  (bus_b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .Hout  (hout),
    .Lout  (lout)
  );

  always #5 clk = ~clk;

  // Issue one request and sample at each falling edge until done (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output int dcnt);
    bcyc = 0;
    dcnt = 0;
    @(negedge clk);
    start = 1'b1; op = o; bus_a = a; bus_b = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy) bcyc++;
      if (done) begin
        dcnt++;
        @(negedge clk);
        if (done) dcnt++;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; bus_a = '0; bus_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (hout !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", hout, 32'h0); end
    total++; if (lout !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", lout, 32'h0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_mult;
    int bc, dc;
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, bc, dc);
    total++; if (bc != MUL_BUSY) begin bad++; $display("FAIL mult_busy got=%0d exp=%0d", bc, MUL_BUSY); end
    total++; if (dc != 1) begin bad++; $display("FAIL mult_done got=%0d exp=1", dc); end
    total++; if (hout !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hout); end
    total++; if (lout !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", lout); end
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
    total++; if (hout !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", hout); end
    total++; if (lout !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", lout); end
    run_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, bc, dc);
    total++; if ({hout, lout} !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mult_pos_neg got=%h exp=ffffffffffffffeb", {hout, lout}); end
    run_op(MD_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, bc, dc);
    total++; if ({hout, lout} !== 64'd20) begin bad++; $display("FAIL mult_neg_neg got=%h exp=%h", {hout, lout}, 64'd20); end
  endtask

  task automatic test_div;
    int bc, dc;
    run_op(MD_DIVU, 32'd100, 32'd7, bc, dc);
    total++; if (bc != 33) begin bad++; $display("FAIL divu_busy got=%0d exp=33", bc); end
    total++; if (dc != 1) begin bad++; $display("FAIL divu_done got=%0d exp=1", dc); end
    total++; if (lout !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h exp=%h", lout, 32'd14); end
    total++; if (hout !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h exp=%h", hout, 32'd2); end
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, bc, dc);
    total++; if (lout !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo got=%h exp=fffffffd", lout); end
    total++; if (hout !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_hi got=%h exp=ffffffff", hout); end
  endtask

  task automatic test_div_corner;
    int bc, dc;
    run_op(MD_DIV, 32'h0000_1234, 32'd0, bc, dc);
    total++; if (bc != 33) begin bad++; $display("FAIL div0_busy got=%0d exp=33", bc); end
    total++; if (lout !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo got=%h exp=ffffffff", lout); end
    total++; if (hout !== 32'h0000_1234) begin bad++; $display("FAIL div0_hi got=%h exp=00001234", hout); end
    run_op(MD_DIV, 32'hFFFF_FFFB, 32'd0, bc, dc);
    total++; if (hout !== 32'hFFFF_FFFB) begin bad++; $display("FAIL div0_neg_hi got=%h exp=fffffffb", hout); end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
    total++; if (lout !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", lout); end
    total++; if (hout !== 32'h0) begin bad++; $display("FAIL div_ovf_hi got=%h exp=00000000", hout); end
  endtask

  task automatic test_mthi_mtlo;
    int bc, dc;
    run_op(MD_MTHI, 32'hDEAD_BEEF, 32'h0, bc, dc);
    total++; if (bc != 0) begin bad++; $display("FAIL mthi_busy got=%0d exp=0", bc); end
    total++; if (dc != 1) begin bad++; $display("FAIL mthi_done got=%0d exp=1", dc); end
    total++; if (hout !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mthi_hi got=%h exp=deadbeef", hout); end
    run_op(MD_MTLO, 32'd5, 32'h0, bc, dc);
    total++; if (bc != 0) begin bad++; $display("FAIL mtlo_busy got=%0d exp=0", bc); end
    total++; if (lout !== 32'd5) begin bad++; $display("FAIL mtlo_lo got=%h exp=00000005", lout); end
    total++; if (hout !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mtlo_hi_keep got=%h exp=deadbeef", hout); end
  endtask

  task automatic test_start_busy;
    int dc;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; bus_a = 32'd100; bus_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = MD_MTHI; bus_a = 32'h0;
    @(negedge clk);
    start = 1'b0;
    total++; if (hout !== 32'hDEAD_BEEF) begin bad++; $display("FAIL busy_start_hi got=%h exp=deadbeef", hout); end
    total++; if (lout !== 32'd5) begin bad++; $display("FAIL busy_old_lo got=%h exp=00000005", lout); end
    seen = 1'b0;
    dc = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) begin seen = 1'b1; dc++; end
      else @(negedge clk);
    end
    total++; if (dc != 1) begin bad++; $display("FAIL busy_start_done got=%0d exp=1", dc); end
    total++; if ({hout, lout} !== {32'd2, 32'd14}) begin bad++; $display("FAIL busy_start_res got=%h exp=%h", {hout, lout}, {32'd2, 32'd14}); end
  endtask

  task automatic test_flush;
    int dc;
    @(negedge clk);
    start = 1'b1; op = FLUSH_OP; bus_a = 32'h1234; bus_b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    total++; if (dc != 0) begin bad++; $display("FAIL flush_done got=%0d exp=0", dc); end
    total++; if ({hout, lout} !== {32'd2, 32'd14}) begin bad++; $display("FAIL flush_keep got=%h exp=%h", {hout, lout}, {32'd2, 32'd14}); end
    // flush together with start in IDLE drops the request
    start = 1'b1; flush = 1'b1; op = MD_MTHI; bus_a = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    total++; if (hout !== 32'd2) begin bad++; $display("FAIL flush_start_hi got=%h exp=00000002", hout); end
    // unknown op ignored
    start = 1'b1; op = 3'd6; bus_a = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL unk_op busy=%b done=%b exp=0 0", busy, done); end
    total++; if ({hout, lout} !== {32'd2, 32'd14}) begin bad++; $display("FAIL unk_op_keep got=%h exp=%h", {hout, lout}, {32'd2, 32'd14}); end
  endtask

  task automatic test_reset_mid;
    int bc, dc;
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; bus_a = 32'd1000; bus_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({hout, lout} !== 64'h0) begin bad++; $display("FAIL rstmid_hilo got=%h exp=0", {hout, lout}); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_flags busy=%b done=%b exp=0 0", busy, done); end
    run_op(MD_DIVU, 32'd9, 32'd3, bc, dc);
    total++; if (bc != 33) begin bad++; $display("FAIL rstmid_busy got=%0d exp=33", bc); end
    total++; if ({hout, lout} !== {32'd0, 32'd3}) begin bad++; $display("FAIL rstmid_res got=%h exp=%h", {hout, lout}, {32'd0, 32'd3}); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_corner;
    test_mthi_mtlo;
    test_start_busy;
    test_flush;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
